fwrisc_exec_formal_branch_seq: RTL
==================================

Name: fwrisc_exec_formal_branch_seq

Overview:
- Parametrised branch stimulus sequencer and self-checker for the fwrisc exec unit. Successor to the single-shot branch driver.
- Issues a programmable-length run of branch ops (EQ/LT/LTU, optionally NE/GE/GEU), with compressed and uncompressed encodings.
- Derives operands that force a chosen taken/not-taken outcome, then checks the exec unit's resulting pc.
- Sits between the bench (formal anyconst or simulation stimulus) and the exec unit decode interface.

Parameters:
- N_INSTR, 8: branches issued per run (1..255).
- N_OPS, 3: branch conditions enabled. 3 = EQ, LT, LTU; 6 adds NE, GE, GEU.
- ENABLE_C, 1: 1 allows compressed (instr_c=1) issue; 0 forces instr_c=0.
- TIMEOUT, 16: max cycles from decode_valid to instr_complete.

Ports:
- clock  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  pulse; begins a run when idle.
- stim_value  in  32  base operand value, sampled at issue.
- stim_op  in  3  condition select; stim_op % N_OPS chooses the op.
- stim_cond  in  1  1 = branch must be taken.
- stim_offset  in  12  raw branch offset.
- stim_c  in  1  request compressed encoding.
- pc  in  32  exec unit program counter.
- instr_complete  in  1  exec unit finished the current op.
- decode_valid  out  1  instruction presented; forced low while instr_complete=1.
- instr_c, op_type[4:0], op_a[31:0], op_b[31:0], op[5:0], op_c[31:0], rd[5:0]  out  decode fields.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at end of run.
- err  out  1  sticky error flag.
- err_code  out  2  0 none, 1 pc mismatch, 2 timeout.
- n_taken  out  8  count of taken branches issued in the run.

Behaviour:
- Reset, asynchronous on reset_n=0: state IDLE; all decode outputs 0 except op_type=OP_TYPE_BRANCH; busy, done, err, err_code, n_taken = 0. Counters cleared. Reset mid-run aborts with no done pulse.
- State machine:
  - IDLE: start=1 -> ISSUE. Clears n_taken, issue count, err, err_code. start is ignored in every other state.
  - ISSUE (1 cycle): sample stim_* and pc into pc_issue; drive decode fields; set decode_valid_r; clear timer -> WAIT.
  - WAIT: instr_complete=1 -> clear decode_valid_r -> CHECK. Timer reaches TIMEOUT -> err=1, err_code=2 -> DONE.
  - CHECK (1 cycle after instr_complete): compare pc with expected.
    - Mismatch: err=1, err_code=1 (first error wins).
    - Then: issue count == N_INSTR -> DONE; otherwise -> ISSUE.
  - DONE: pulse done for 1 cycle -> IDLE.
- Operand rules, with v = stim_value:
  - EQ: taken -> a=b=v; not taken -> a=v, b=~v.
  - NE: the inverse of EQ.
  - LT: taken -> a=v, b=v+1. If v==32'h7FFFFFFF, use a=v-1, b=v instead. Not taken -> a=b=v.
  - GE: taken -> a=b=v; not taken uses the LT-taken operands.
  - LTU/GEU: same as LT/GE, but the wrap guard is v==32'hFFFFFFFF.
- Encoding: instr_c = stim_c & ENABLE_C.
- op_c = sign-extended {stim_offset[11:1], 1'b0}. A zero result is replaced by 4.
- Expected pc: taken -> pc_issue + op_c; not taken -> pc_issue + (instr_c ? 2 : 4). 32-bit wrap-around.
- n_taken increments in ISSUE when stim_cond=1; saturates at 255.
- rd = 0 always. decode_valid = decode_valid_r & ~instr_complete.
- instr_complete arriving in the same cycle as ISSUE is not a completion; it is only honoured in WAIT.

Test Plan:
- N_INSTR=1, EQ, v=5, cond=1, offset=12'h010, pc=0x100 -> op_a=op_b=5, op_c=0x10; exec gives pc 0x110 -> done, err=0, n_taken=1.
- LT, v=0x7FFFFFFF, cond=1 -> op_a=0x7FFFFFFE, op_b=0x7FFFFFFF; correct pc -> no error.
- LTU not taken, stim_c=1, ENABLE_C=1, pc=0x200 -> instr_c=1, expected pc 0x202; exec returns 0x204 -> err=1, err_code=1.
- instr_complete held low -> after 16 WAIT cycles err_code=2 and done pulses.
- N_INSTR=8, N_OPS=6, alternating cond -> 8 issues, n_taken=4, single done pulse.
- reset_n asserted during WAIT -> all outputs return to reset values immediately; start after release begins a fresh run.

Source files
------------

// File: rtl/fwrisc_exec_formal_branch_seq.sv
// fwrisc_exec_formal_branch_seq: issues a run of branch ops with outcome-forcing operands and checks the resulting pc
module fwrisc_exec_formal_branch_seq #(
    parameter int N_INSTR  = 8,
    parameter int N_OPS    = 3,
    parameter int ENABLE_C = 1,
    parameter int TIMEOUT  = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] stim_value,
    input  logic [2:0]  stim_op,
    input  logic        stim_cond,
    input  logic [11:0] stim_offset,
    input  logic        stim_c,
    input  logic [31:0] pc,
    input  logic        instr_complete,
    output logic        decode_valid,
    output logic        instr_c,
    output logic [4:0]  op_type,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    output logic [5:0]  op,
    output logic [31:0] op_c,
    output logic [5:0]  rd,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [7:0]  n_taken
);
    localparam logic [4:0] OP_TYPE_BRANCH = 5'd1;
    localparam logic [5:0] COND_EQ = 6'd0, COND_NE = 6'd1, COND_LT = 6'd2;
    localparam logic [5:0] COND_GE = 6'd3, COND_LTU = 6'd4, COND_GEU = 6'd5;
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CHECK, DONE} state_t;
    state_t      state;
    logic        decode_valid_r;
    logic [7:0]  issue_cnt;
    logic [15:0] timer;
    logic [31:0] exp_pc;
    // sel: 0 EQ, 1 LT, 2 LTU, 3 NE, 4 GE, 5 GEU; upper half inverts the sense of the lower half
    logic [2:0]  sel;
    logic        is_u, is_eq, inv, flip, nxt_ic;
    logic [31:0] guard, lt_a, lt_b, nxt_a, nxt_b, raw_off, nxt_off, nxt_pc;
    logic [5:0]  nxt_op;
    assign sel     = 3'(32'(stim_op) % N_OPS);
    assign is_u    = (sel == 3'd2) || (sel == 3'd5);
    assign is_eq   = (sel == 3'd0) || (sel == 3'd3);
    assign inv     = sel >= 3'd3;
    assign flip    = stim_cond ^ inv;
    assign guard   = is_u ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
    assign lt_a    = (stim_value == guard) ? stim_value - 32'd1 : stim_value;
    assign lt_b    = (stim_value == guard) ? stim_value : stim_value + 32'd1;
    assign nxt_a   = (is_eq || !flip) ? stim_value : lt_a;
    assign nxt_b   = is_eq ? (flip ? stim_value : ~stim_value) : (flip ? lt_b : stim_value);
    assign nxt_op  = is_eq ? (inv ? COND_NE : COND_EQ) :
                     is_u  ? (inv ? COND_GEU : COND_LTU) : (inv ? COND_GE : COND_LT);
    assign raw_off = {{20{stim_offset[11]}}, stim_offset[11:1], 1'b0};
    assign nxt_off = (raw_off == 32'd0) ? 32'd4 : raw_off;
    assign nxt_ic  = stim_c & (ENABLE_C != 0);
    assign nxt_pc  = stim_cond ? pc + nxt_off : pc + (nxt_ic ? 32'd2 : 32'd4);
    assign decode_valid = decode_valid_r & ~instr_complete;
    assign rd = '0;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            decode_valid_r <= 1'b0;
            instr_c        <= 1'b0;
            op_type        <= OP_TYPE_BRANCH;
            op_a           <= '0;
            op_b           <= '0;
            op             <= '0;
            op_c           <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
            err_code       <= '0;
            n_taken        <= '0;
            issue_cnt      <= '0;
            timer          <= '0;
            exp_pc         <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state     <= ISSUE;
                    busy      <= 1'b1;
                    n_taken   <= '0;
                    issue_cnt <= '0;
                    err       <= 1'b0;
                    err_code  <= '0;
                end
                ISSUE: begin
                    op_a           <= nxt_a;
                    op_b           <= nxt_b;
                    op             <= nxt_op;
                    op_c           <= nxt_off;
                    instr_c        <= nxt_ic;
                    exp_pc         <= nxt_pc;
                    decode_valid_r <= 1'b1;
                    timer          <= '0;
                    issue_cnt      <= issue_cnt + 8'd1;
                    if (stim_cond && n_taken != 8'hFF) n_taken <= n_taken + 8'd1;
                    state          <= WAIT;
                end
                WAIT: if (instr_complete) begin
                    decode_valid_r <= 1'b0;
                    state          <= CHECK;
                end else if (timer + 16'd1 == 16'(TIMEOUT)) begin
                    decode_valid_r <= 1'b0;
                    err            <= 1'b1;
                    if (!err) err_code <= 2'd2;
                    done           <= 1'b1;
                    state          <= DONE;
                end else begin
                    timer <= timer + 16'd1;
                end
                CHECK: begin
                    if (pc != exp_pc) begin
                        err <= 1'b1;
                        if (!err) err_code <= 2'd1;
                    end
                    if (issue_cnt == 8'(N_INSTR)) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        state <= ISSUE;
                    end
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
